// File: rtl/bwn_stream_layer.sv
// bwn_stream_layer -- binary-weight streaming layer.
//
// Each accepted beat carries CH channels of K signed taps together with one
// binary weight per tap (1 = add, 0 = subtract). The beat sum is accumulated
// over NPASS beats and compared against a signed threshold to give one bit
// per output pixel. POOL consecutive bits are OR-ed (binary max-pool). The
// pooled bits are packed MSB-first into BL-bit words.
//
// Optional feature macro: BWN_THRESH_INV_EN
//   When defined, input iINV exists; iINV=1 turns the threshold test into
//   (ACC+S1) < iTH. When undefined, the test is always (ACC+S1) > iTH.
//
// Ports:
//   iCLK     clock, all state on the rising edge
//   iRST     asynchronous active-low reset
//   iSTART   synchronous clear of all datapath state (wins over iVALID)
//   iVALID   beat strobe, no backpressure
//   iDATA    WL*CH*K signed words, channel c tap k at bit (c*K+k)*WL
//   iWEIGHT  CH*K binary weights, same ordering as iDATA
//   iTH      AW-bit signed threshold, sampled with the last pass of a pixel
//   iINV     (BWN_THRESH_INV_EN only) invert the threshold comparison
//   iEN      packer enable; pooled bits arriving with iEN=0 are dropped
//   oDATA    last completed packed word, held between updates
//   oVALID   one-cycle pulse when oDATA is updated
module bwn_stream_layer #(
  parameter int WL    = 8,
  parameter int CH    = 12,
  parameter int K     = 9,
  parameter int NPASS = 1,
  parameter int POOL  = 2,
  parameter int BL    = 154,
  parameter int AW    = 27
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic                 iVALID,
  input  logic [WL*CH*K-1:0]   iDATA,
  input  logic [CH*K-1:0]      iWEIGHT,
  input  logic [AW-1:0]        iTH,
`ifdef BWN_THRESH_INV_EN
  input  logic                 iINV,
`endif
  input  logic                 iEN,
  output logic [BL-1:0]        oDATA,
  output logic                 oVALID
);

  localparam int NTAP = CH * K;
  localparam int EXT  = AW - WL;
  localparam int PW   = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int PLW  = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int FW   = (BL > 1) ? $clog2(BL) : 1;
  localparam int SRW  = BL - 1;

  // Stage 1: beat sum
  logic signed [AW-1:0] s1_q, s1_d;
  logic                 s1_vld_q, s1_vld_d;

  // Stage 2: multi-pass accumulate and threshold
  logic signed [AW-1:0] acc_q, acc_d;
  logic [PW-1:0]        pass_q, pass_d;
  logic                 thr_bit_q, thr_bit_d;
  logic                 thr_vld_q, thr_vld_d;

  // Stage 3: pooling and packing
  logic                 por_q, por_d;
  logic [PLW-1:0]       pool_q, pool_d;
  logic [SRW-1:0]       sr_q, sr_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [BL-1:0]        odata_q, odata_d;
  logic                 ovalid_q, ovalid_d;

  logic signed [WL-1:0] tap;
  logic signed [AW-1:0] tap_ext;
  logic signed [AW-1:0] tot;
  logic                 cmp;
  logic                 pooled;

  // Stage 1 adder tree: each tap is sign-extended to AW and added or
  // subtracted according to its weight; wraps in AW bits.
  always_comb begin
    s1_d    = '0;
    tap     = '0;
    tap_ext = '0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      tap     = iDATA[i*WL +: WL];
      tap_ext = {{EXT{tap[WL-1]}}, tap};
      s1_d    = iWEIGHT[i] ? (s1_d + tap_ext) : (s1_d - tap_ext);
    end
    s1_vld_d = iVALID;
  end

  // Stage 2
  always_comb begin
    tot = acc_q + s1_q;
`ifdef BWN_THRESH_INV_EN
    cmp = iINV ? (tot < $signed(iTH)) : (tot > $signed(iTH));
`else
    cmp = tot > $signed(iTH);
`endif
    acc_d     = acc_q;
    pass_d    = pass_q;
    thr_bit_d = thr_bit_q;
    thr_vld_d = 1'b0;
    if (s1_vld_q) begin
      if (pass_q != PW'(NPASS - 1)) begin
        acc_d  = tot;
        pass_d = pass_q + PW'(1);
      end else begin
        thr_bit_d = cmp;
        thr_vld_d = 1'b1;
        acc_d     = '0;
        pass_d    = '0;
      end
    end
  end

  // Stage 3: the pooled bit is formed from the OR register and the arriving
  // bit so the POOL-th bit needs no extra cycle. The packed word is built
  // from the BL-1 previously shifted bits plus the arriving bit, so a full
  // word is loaded into oDATA on the same edge the last bit arrives.
  always_comb begin
    pooled   = por_q | thr_bit_q;
    por_d    = por_q;
    pool_d   = pool_q;
    sr_d     = sr_q;
    fill_d   = fill_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    if (thr_vld_q) begin
      if (pool_q == PLW'(POOL - 1)) begin
        por_d  = 1'b0;
        pool_d = '0;
        if (iEN) begin
          sr_d = SRW'({sr_q, pooled});
          if (fill_q == FW'(BL - 1)) begin
            odata_d  = {sr_q, pooled};
            ovalid_d = 1'b1;
            fill_d   = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
      end else begin
        por_d  = pooled;
        pool_d = pool_q + PLW'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      acc_q     <= '0;
      pass_q    <= '0;
      thr_bit_q <= 1'b0;
      thr_vld_q <= 1'b0;
      por_q     <= 1'b0;
      pool_q    <= '0;
      sr_q      <= '0;
      fill_q    <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
    end else if (iSTART) begin
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      acc_q     <= '0;
      pass_q    <= '0;
      thr_bit_q <= 1'b0;
      thr_vld_q <= 1'b0;
      por_q     <= 1'b0;
      pool_q    <= '0;
      sr_q      <= '0;
      fill_q    <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      acc_q     <= acc_d;
      pass_q    <= pass_d;
      thr_bit_q <= thr_bit_d;
      thr_vld_q <= thr_vld_d;
      por_q     <= por_d;
      pool_q    <= pool_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
    end
  end

  assign oDATA  = odata_q;
  assign oVALID = ovalid_q;

endmodule
